// File: rtl/dmem_pkg.sv
// Shared types and helpers for the parametrised data memory controller.
// Lane masks and load extension live here so the datapath can reuse them.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } mem_size_t;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } dmem_state_t;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } lat_entry_t;

    function automatic logic [3:0] lane_mask(input mem_size_t size, input logic [1:0] lane);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001 << lane;
            SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_replicate(input mem_size_t size, input logic [31:0] wdata);
        logic [31:0] r;
        case (size)
            SZ_BYTE: r = {4{wdata[7:0]}};
            SZ_HALF: r = {2{wdata[15:0]}};
            default: r = wdata;
        endcase
        return r;
    endfunction

    // Shift the addressed lane down to bit 0, then extend to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input mem_size_t size,
                                                input logic [1:0] lane, input logic is_unsigned);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {lane, 3'b000};
        case (size)
            SZ_BYTE: r = is_unsigned ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: r = is_unsigned ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_lat_pipe.sv
// Fixed-depth response delay line carrying {valid, err, data}.
// Synchronous active-low clear drops every in-flight response.
module dmem_lat_pipe
    import dmem_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  lat_entry_t in_entry,
    output lat_entry_t out_entry
);

    lat_entry_t stage [RD_LAT];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= in_entry;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign out_entry = stage[RD_LAT-1];

endmodule

// File: rtl/dmem_ctrl.sv
// Configurable-depth data memory with byte/half/word access, error reporting,
// a post-reset clear sequencer and a fixed-latency in-order response path.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   ram [DEPTH-1:0];
    dmem_state_t   state;
    logic [AW-1:0] clr_cnt;

    mem_size_t     size;
    logic [AW-1:0] idx;
    logic          accept;
    logic          misaligned;
    logic          out_of_range;
    logic          err;
    logic          wr_en;
    logic [3:0]    mask;
    logic [31:0]   wrep;
    logic [31:0]   rd_word;
    lat_entry_t    pipe_in;
    lat_entry_t    pipe_out;

    assign size         = mem_size_t'(req_size);
    assign idx          = req_addr[AW+1:2];
    assign req_ready    = (state == READY);
    assign accept       = req_valid && req_ready;
    assign misaligned   = ((size == SZ_HALF) && req_addr[0]) ||
                          ((size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign out_of_range = |req_addr[31:AW+2];
    assign err          = misaligned || out_of_range || (size == SZ_BAD);
    assign wr_en        = accept && !err && req_write;
    assign mask         = lane_mask(size, req_addr[1:0]);
    assign wrep         = store_replicate(size, req_wdata);
    assign rd_word      = ram[idx];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + AW'(1);
            if (clr_cnt == '1) begin
                state <= READY;
            end
        end
    end

    // Clear and request writes are mutually exclusive: requests are only accepted in READY.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (state == CLEAR) begin
                ram[clr_cnt] <= '0;
            end else if (wr_en) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (mask[i]) begin
                        ram[idx][8*i +: 8] <= wrep[8*i +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        pipe_in       = '0;
        pipe_in.valid = accept;
        pipe_in.err   = accept && err;
        if (accept && !err && !req_write) begin
            pipe_in.data = load_extend(rd_word, size, req_addr[1:0], req_unsigned);
        end
    end

    dmem_lat_pipe #(
        .RD_LAT (RD_LAT)
    ) u_lat_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_entry  (pipe_in),
        .out_entry (pipe_out)
    );

    assign resp_valid = pipe_out.valid;
    assign resp_err   = pipe_out.err;
    assign resp_data  = pipe_out.data;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus random traffic
// checked against a byte-array reference model with a due-cycle response queue.
module tb_dmem_ctrl;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned RD_LAT = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    dmem_ctrl #(
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_err     (resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          clear_left = DEPTH;
    bit          started = 1'b0;
    logic [7:0]  mem [DEPTH*4];
    exp_t        q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: memory as bytes, accesses as runs of n bytes starting at the address.
    task automatic model_req(output logic e, output logic [31:0] d);
        int          n;
        int          a;
        logic [31:0] v;
        n = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
        e = (req_size == 2'd3) || ((req_addr % n) != 0) || (req_addr >= DEPTH*4);
        d = '0;
        if (!e) begin
            a = int'(req_addr);
            if (req_write) begin
                for (int k = 0; k < n; k++) mem[a+k] = req_wdata[8*k +: 8];
            end else begin
                v = '0;
                for (int k = 0; k < n; k++) v = v | (32'(mem[a+k]) << (8*k));
                if (!req_unsigned && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                d = v;
            end
        end
    endtask

    task automatic step();
        logic        acc;
        logic        e;
        logic [31:0] d;
        bit          due;
        e = 1'b0;
        d = '0;
        acc = reset_n && req_valid && (clear_left == 0);
        if (acc) model_req(e, d);
        @(posedge clk);
        cyc++;
        if (!reset_n) begin
            clear_left = DEPTH;
            q.delete();
            foreach (mem[i]) mem[i] = 8'h00;
            started = 1'b1;
        end else if (clear_left > 0) begin
            clear_left--;
        end
        if (acc) q.push_back('{cyc + RD_LAT - 1, e, d});
        #1;
        if (started) begin
            check("req_ready", 32'(req_ready), 32'(clear_left == 0));
            due = (q.size() > 0) && (q[0].due == cyc);
            check("resp_valid", 32'(resp_valid), 32'(due));
            if (due) begin
                check("resp_err", 32'(resp_err), 32'(q[0].err));
                check("resp_data", resp_data, q[0].data);
                void'(q.pop_front());
            end
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic req(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        step();
        req_valid    = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle(3);
        check("reset_resp_data", resp_data, 32'h0);
        check("reset_resp_err", 32'(resp_err), 32'h0);
        reset_n = 1'b1;
        idle(DEPTH);

        req(1'b0, 2'd2, 1'b0, 32'h0000_00FC, 32'h0);
        idle(RD_LAT);

        req(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344);
        req(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AA);
        req(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_BEEF);
        req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        idle(RD_LAT);

        req(1'b1, 2'd2, 1'b0, 32'h20, 32'h0000_80F0);
        req(1'b0, 2'd0, 1'b0, 32'h20, 32'h0);
        req(1'b0, 2'd0, 1'b1, 32'h20, 32'h0);
        req(1'b0, 2'd1, 1'b0, 32'h20, 32'h0);
        req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
        idle(RD_LAT);

        req(1'b0, 2'd1, 1'b0, 32'h21, 32'h0);
        req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF);
        req(1'b1, 2'd3, 1'b0, 32'h00, 32'hFFFF_FFFF);
        req(1'b1, 2'd2, 1'b0, 32'h8000_0000, 32'h1234_5678);
        req(1'b0, 2'd2, 1'b0, 32'h00, 32'h0);
        idle(RD_LAT);

        req(1'b1, 2'd2, 1'b0, 32'h08, 32'hCAFE_F00D);
        req(1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
        req(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0);
        idle(RD_LAT + 1);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 9))
                0:       a = $urandom_range(256, 300);
                1:       a = $urandom | 32'h0001_0000;
                default: a = $urandom_range(0, 255);
            endcase
            if ($urandom_range(0, 3) != 0) begin
                req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
            end else begin
                idle(1);
            end
        end
        idle(RD_LAT);

        req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(DEPTH + 4);
        req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        idle(RD_LAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
